// File: rtl/serial_comparator_pkg.sv
// Shared encodings for the serial magnitude comparator.
package serial_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Result word is {GT, EQ, LT}, one-hot when valid.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/serial_comparator_if.sv
// Serial operand / result bundle between a bit source and the comparator.
interface serial_comparator_if;

    logic start;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic busy;
    logic done;
    logic aGTb;
    logic aEQb;
    logic aLTb;

    modport master (
        output start, bit_valid, a_bit, b_bit,
        input  busy, done, aGTb, aEQb, aLTb
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
        output busy, done, aGTb, aEQb, aLTb
    );

endinterface

// File: rtl/serial_comparator_bit1.sv
// Single-bit magnitude comparator used on each serial operand bit.
module bit1_comparator (
    input  logic a_i,
    input  logic b_i,
    output logic gt_o,
    output logic eq_o,
    output logic lt_o
);

    assign gt_o = a_i & ~b_i;
    assign eq_o = ~(a_i ^ b_i);
    assign lt_o = ~a_i & b_i;

endmodule

// File: rtl/serial_comparator.sv
// Serial MSB-first magnitude comparator: consumes WIDTH valid bit pairs,
// latches the first differing position, and reports GT/EQ/LT with a done pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; result flags hold the last outcome
// COMPARE | consuming operand bits; start is ignored, busy=1
// DONE    | one-cycle result strobe; start here chains a new compare
module serial_comparator
    import serial_comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_comparator_if.slave  bus
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic [2:0]       res_q, res_d;
    logic [2:0]       flags_q, flags_d;
    logic             bit_gt, bit_eq, bit_lt;

    bit1_comparator u_bit_cmp (
        .a_i  (bus.a_bit),
        .b_i  (bus.b_bit),
        .gt_o (bit_gt),
        .eq_o (bit_eq),
        .lt_o (bit_lt)
    );

    // Next-state: the terminal count on a valid bit is the only way out of COMPARE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = COMPARE;
            COMPARE: if (bus.bit_valid && (cnt_q == LAST_BIT)) state_d = DONE;
            DONE:    state_d = bus.start ? COMPARE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counting, first-difference latching and result publication.
    always_comb begin
        cnt_d     = cnt_q;
        decided_d = decided_q;
        res_d     = res_q;
        flags_d   = flags_q;
        if ((state_q != COMPARE) && (state_d == COMPARE)) begin
            // Any bit presented alongside an accepted start is not counted.
            cnt_d     = '0;
            decided_d = 1'b0;
            res_d     = RES_NONE;
            flags_d   = RES_NONE;
        end else if ((state_q == COMPARE) && bus.bit_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!decided_q && !bit_eq) begin
                decided_d = 1'b1;
                res_d     = {bit_gt, 1'b0, bit_lt};
            end
            // The last bit may itself be the deciding one, so use the _d view.
            if (state_d == DONE) begin
                flags_d = decided_d ? res_d : RES_EQ;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            res_q     <= RES_NONE;
            flags_q   <= RES_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
        end
    end

    assign bus.busy = (state_q == COMPARE);
    assign bus.done = (state_q == DONE);
    assign {bus.aGTb, bus.aEQb, bus.aLTb} = flags_q;

endmodule
